// File: rtl/alu_iter_if.sv
// Handshake and operand bundle between the ID/EX register, the EX-stage ALU and
// the hazard unit. The requester drives the master side.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             illegal_o;
  logic             busy_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, valid_o, illegal_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, valid_o, illegal_o, busy_o
  );
endinterface

// File: rtl/alu_iter.sv
// EX-stage ALU: single-cycle logic/shift/add ops plus an iterative radix-2
// shift-add multiplier that holds busy_o while it runs.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_iter_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_XOR  = 4'b0001,
    OP_SLL  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_MUL  = 4'b0101,
    OP_SRAI = 4'b0111
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             illegal_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_illegal;
  logic [WIDTH-1:0] acc_next;

  assign shamt    = bus.data2_i[SHW-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    alu_result  = '0;
    alu_illegal = 1'b0;
    case (bus.ALUCtrl_i)
      OP_AND:  alu_result = bus.data1_i & bus.data2_i;
      OP_XOR:  alu_result = bus.data1_i ^ bus.data2_i;
      OP_SLL:  alu_result = bus.data1_i << shamt;
      OP_ADD:  alu_result = bus.data1_i + bus.data2_i;
      OP_SUB:  alu_result = bus.data1_i - bus.data2_i;
      OP_SRAI: alu_result = WIDTH'($signed(bus.data1_i) >>> shamt);
      OP_MUL:  alu_result = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the datapath registers are few and all reset, so an aborted multiply
  // never leaks partial state into the next operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.ALUCtrl_i == OP_MUL) begin
              mcand  <= bus.data1_i;
              mplier <= bus.data2_i;
              acc    <= '0;
              count  <= '0;
              state  <= S_MUL;
            end else begin
              data_q    <= alu_result;
              valid_q   <= 1'b1;
              illegal_q <= alu_illegal;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // The last iteration's partial sum goes straight to the result.
          if (count == LAST_ITER) begin
            data_q  <= acc_next;
            valid_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_o    = data_q;
  assign bus.valid_o   = valid_q;
  assign bus.illegal_o = illegal_q;
  assign bus.busy_o    = (state == S_MUL);
endmodule

// File: tb/tb_alu_iter.sv
// Randomized and directed bench for alu_iter against an arithmetic reference
// model of the ALU codes.
module tb_alu_iter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(WIDTH)) bus ();

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Expected result straight from the ALU code definitions.
  function automatic logic [WIDTH-1:0] model(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    int unsigned sh;
    logic [2*WIDTH-1:0] prod;
    sh   = b % WIDTH;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      4'd0:    return a & b;
      4'd1:    return a ^ b;
      4'd2:    return a << sh;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return prod[WIDTH-1:0];
      4'd7:    return WIDTH'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

  function automatic logic model_illegal(input logic [3:0] op);
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue(4'd3, 32'd1, 32'd1);
    tick();
    tick();
    vectors++;
    if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b000, {WIDTH{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%b b=%b d=%h, want all zero",
               bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o);
    end
    rst = 1'b0;
    bus.start_i = 1'b0;
    tick();
    vectors++;
    if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b000, {WIDTH{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_idle: got v=%b i=%b b=%b d=%h, want all zero",
               bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o);
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]       ops [2] = '{4'd3, 4'd4};
    logic [WIDTH-1:0] as  [2] = '{32'h7FFF_FFFF, 32'd5};
    logic [WIDTH-1:0] bs  [2] = '{32'h0000_0001, 32'd7};
    logic [WIDTH-1:0] exp [2] = '{32'h8000_0000, 32'hFFFF_FFFE};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], as[i], bs[i]);
      tick();
      bus.start_i = 1'b0;
      vectors++;
      if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b100, exp[i]}) begin
        miscompares++;
        $display("FAIL add_sub[%0d]: got v=%b i=%b b=%b d=%h, want v=1 i=0 b=0 d=%h",
                 i, bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]       ops [4] = '{4'd1, 4'd0, 4'd2, 4'd7};
    logic [WIDTH-1:0] as  [4] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1, 32'h8000_0000};
    logic [WIDTH-1:0] bs  [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'h3F, 32'h4};
    logic [WIDTH-1:0] exp [4] = '{32'h0F0F_F0F0, 32'hF0F0_0000, 32'h8000_0000, 32'hF800_0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      tick();
      vectors++;
      if ({bus.valid_o, bus.illegal_o, bus.data_o} !== {2'b10, exp[i]}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got v=%b i=%b d=%h, want v=1 i=0 d=%h",
                 i, bus.valid_o, bus.illegal_o, bus.data_o, exp[i]);
      end
    end
    bus.start_i = 1'b0;
    tick();
    vectors++;
    if ({bus.valid_o, bus.data_o} !== {1'b0, exp[3]}) begin
      miscompares++;
      $display("FAIL b2b_hold: got v=%b d=%h, want v=0 d=%h", bus.valid_o, bus.data_o, exp[3]);
    end
  endtask

  task automatic test_random_single();
    logic [3:0] pool [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    for (int i = 0; i < 60; i++) begin
      logic [3:0]       op;
      logic [WIDTH-1:0] a, b, exp;
      op  = pool[$urandom_range(0, 5)];
      a   = $urandom;
      b   = $urandom;
      exp = model(op, a, b);
      issue(op, a, b);
      tick();
      vectors++;
      if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b100, exp}) begin
        miscompares++;
        $display("FAIL rand_single op=%h a=%h b=%h: got v=%b i=%b b=%b d=%h, want d=%h",
                 op, a, b, bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o, exp);
      end
    end
    bus.start_i = 1'b0;
    tick();
  endtask

  // Issues one MUL and checks busy length, quiet valid_o, and the final result.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   n;
    logic early_valid;
    logic [WIDTH-1:0] exp;
    exp = model(4'd5, a, b);
    issue(4'd5, a, b);
    tick();
    bus.start_i = 1'b0;
    n = 0;
    early_valid = 1'b0;
    while (bus.busy_o && n < 200) begin
      if (bus.valid_o) early_valid = 1'b1;
      n++;
      tick();
    end
    vectors++;
    if (n !== WIDTH || early_valid) begin
      miscompares++;
      $display("FAIL mul_busy a=%h b=%h: busy cycles %0d early_valid=%b, want %0d and 0",
               a, b, n, early_valid, WIDTH);
    end
    vectors++;
    if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b100, exp}) begin
      miscompares++;
      $display("FAIL mul_result a=%h b=%h: got v=%b i=%b b=%b d=%h, want d=%h",
               a, b, bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o, exp);
    end
    tick();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_pulse: valid_o got %b the cycle after, want 0", bus.valid_o);
    end
  endtask

  task automatic test_mul();
    run_mul(32'd12345, 32'd6789);
    run_mul(32'hFFFF_FFFF, 32'd3);
    run_mul(32'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) run_mul($urandom, $urandom);
  endtask

  task automatic test_hold_during_busy();
    int n;
    logic [WIDTH-1:0] a, b, c, d;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    d = $urandom;
    issue(4'd5, a, b);
    tick();
    issue(4'd3, c, d);
    n = 0;
    while (bus.busy_o && n < 200) begin
      n++;
      tick();
    end
    vectors++;
    if ({bus.valid_o, bus.data_o} !== {1'b1, model(4'd5, a, b)} || n !== WIDTH) begin
      miscompares++;
      $display("FAIL hold_mul: got v=%b d=%h after %0d busy, want v=1 d=%h after %0d",
               bus.valid_o, bus.data_o, n, model(4'd5, a, b), WIDTH);
    end
    tick();
    bus.start_i = 1'b0;
    vectors++;
    if ({bus.valid_o, bus.busy_o, bus.data_o} !== {2'b10, model(4'd3, c, d)}) begin
      miscompares++;
      $display("FAIL hold_add: got v=%b b=%b d=%h, want v=1 b=0 d=%h",
               bus.valid_o, bus.busy_o, bus.data_o, model(4'd3, c, d));
    end
    tick();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_once: valid_o got %b, want 0", bus.valid_o);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen_valid;
    issue(4'd5, $urandom, $urandom);
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b000, {WIDTH{1'b0}}}) begin
      miscompares++;
      $display("FAIL rst_mid_mul: got v=%b i=%b b=%b d=%h, want all zero",
               bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o || bus.busy_o) seen_valid = 1'b1;
      tick();
    end
    vectors++;
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort: got activity after abort, want none");
    end
    run_mul(32'd2, 32'd3);
  endtask

  task automatic test_illegal();
    logic [3:0] codes [4] = '{4'b1000, 4'b0110, 4'b1111, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      issue(codes[i], $urandom, $urandom);
      tick();
      bus.start_i = 1'b0;
      vectors++;
      if ({bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o} !== {3'b110, {WIDTH{1'b0}}}
          || model_illegal(codes[i]) !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal[%h]: got v=%b i=%b b=%b d=%h, want v=1 i=1 b=0 d=0",
                 codes[i], bus.valid_o, bus.illegal_o, bus.busy_o, bus.data_o);
      end
      tick();
      vectors++;
      if ({bus.valid_o, bus.illegal_o, bus.busy_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL illegal_once[%h]: got v=%b i=%b b=%b, want 0 0 0",
                 codes[i], bus.valid_o, bus.illegal_o, bus.busy_o);
      end
    end
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = 4'd0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_random_single();
    test_mul();
    test_hold_during_busy();
    test_reset_mid_mul();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
